// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   Operand register file with per-register busy scoreboard.
//   Two combinational read ports (A, B) feed the Ra/Rb operand latch; one
//   synchronous write-back port returns ALU results. A busy bit per register
//   marks an outstanding write. It blocks operand reads of that register
//   (rd_stall) and a second issue to the same destination (iss_stall).
//
//   Optional feature macro: REGFILE_SB_BYPASS_EN
//     defined   - write-back data is forwarded to the read ports in the
//                 write-back cycle, so a busy operand is consumed without stall.
//     undefined - read data always comes from the array. A busy operand stalls
//                 until the cycle after its write-back edge.
//
// Parameters
//   DW  data width of each register and data port
//   AW  address width; NREG = 2**AW registers
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (array and scoreboard cleared)
//   ra_addr    read port A address
//   rb_addr    read port B address
//   rd_req     operand read request (operand latch load = rd_req & ~rd_stall)
//   a_data     port A read data, combinational
//   b_data     port B read data, combinational
//   rd_stall   read request blocked by a busy, unforwarded operand
//   iss_en     issue strobe: mark iss_addr busy
//   iss_addr   destination register of the issuing instruction
//   iss_stall  issue blocked: destination already busy and not cleared now
//   wr_en      write-back strobe
//   wr_addr    write-back address
//   wr_data    write-back data
//   busy_vec   registered scoreboard, bit i = register i pending
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       ra_addr,
  input  logic [AW-1:0]       rb_addr,
  input  logic                rd_req,
  output logic [DW-1:0]       a_data,
  output logic [DW-1:0]       b_data,
  output logic                rd_stall,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_stall,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  output logic [(1<<AW)-1:0]  busy_vec
);

  localparam int NREG = 1 << AW;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   r_mem [NREG];
  logic [NREG-1:0] r_busy;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic            w_wr_live;     // write-back strobe, suppressed during reset
  logic            w_wr_hits_iss; // write-back clears the issuing destination now
  logic            w_iss_stall;
  logic            w_iss_go;      // issue accepted this cycle
  logic            w_hit_a;
  logic            w_hit_b;
  logic            w_fwd_a;
  logic            w_fwd_b;
  logic [NREG-1:0] w_busy_nxt;

  assign w_wr_live     = wr_en & ~rst;
  assign w_wr_hits_iss = w_wr_live & (wr_addr == iss_addr);

  // An issue to a busy destination waits unless that register's write-back
  // lands in this same cycle; then the new producer takes ownership.
  assign w_iss_stall = iss_en & ~rst & r_busy[iss_addr] & ~w_wr_hits_iss;
  assign w_iss_go    = iss_en & ~rst & ~w_iss_stall;

  assign w_hit_a = r_busy[ra_addr];
  assign w_hit_b = r_busy[rb_addr];

`ifdef REGFILE_SB_BYPASS_EN
  assign w_fwd_a = w_wr_live & (wr_addr == ra_addr);
  assign w_fwd_b = w_wr_live & (wr_addr == rb_addr);
`else
  assign w_fwd_a = 1'b0;
  assign w_fwd_b = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  always_comb begin
    a_data = r_mem[ra_addr];
    b_data = r_mem[rb_addr];
    if (w_fwd_a) a_data = wr_data;
    if (w_fwd_b) b_data = wr_data;
  end

  assign rd_stall  = rd_req & ~rst & ((w_hit_a & ~w_fwd_a) | (w_hit_b & ~w_fwd_b));
  assign iss_stall = w_iss_stall;
  assign busy_vec  = r_busy;

  // ---------------------------------------------------------------------------
  // Scoreboard next state: clear first, then set, so set wins on a collision.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_live) w_busy_nxt[wr_addr]  = 1'b0;
    if (w_iss_go)  w_busy_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ra_addr, rb_addr, iss_addr, wr_addr;
  logic          rd_req, iss_en, wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] a_data, b_data;
  logic          rd_stall, iss_stall;
  logic [7:0]    busy_vec;

  int checks   = 0;
  int failures = 0;

  regfile_sb #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_req(rd_req),
    .a_data(a_data), .b_data(b_data), .rd_stall(rd_stall),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(iss_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs checked well away from either clock edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ra_addr = '0; rb_addr = '0; rd_req = 1'b0;
    iss_en = 1'b0; iss_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step(); step();
    #1;
    check("rst_busy", {24'h0, busy_vec}, 32'h0);
    check("rst_a", {16'h0, a_data}, 32'h0);
    rst = 1'b0;

    // T1: preload R3, then reset mid-cycle
    step(); wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
    step(); wr_en = 1'b0; ra_addr = 3'd3;
    #1 check("t1_preload", {16'h0, a_data}, 32'h1234);
    step(); iss_en = 1'b1; iss_addr = 3'd3; rd_req = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("t1_rst_r3", {16'h0, a_data}, 32'h0);
    check("t1_rst_busy", {24'h0, busy_vec}, 32'h0);
    check("t1_rst_rdstall", {31'h0, rd_stall}, 32'h0);
    check("t1_rst_isstall", {31'h0, iss_stall}, 32'h0);
    // write-back during reset is ignored
    iss_en = 1'b0; rd_req = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h5555;
    step(); wr_en = 1'b0; rst = 1'b0;
    #1 check("t1_wr_in_rst", {16'h0, a_data}, 32'h0);

    // T2: write R5, read on both ports
    step(); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
    step(); wr_en = 1'b0; ra_addr = 3'd5; rb_addr = 3'd5; rd_req = 1'b1;
    #1;
    check("t2_a", {16'h0, a_data}, 32'hBEEF);
    check("t2_b", {16'h0, b_data}, 32'hBEEF);
    check("t2_stall", {31'h0, rd_stall}, 32'h0);
    rd_req = 1'b0;

    // T3: issue R2, read it, write back
    step(); iss_en = 1'b1; iss_addr = 3'd2;
    #1 check("t3_iss_nostall", {31'h0, iss_stall}, 32'h0);
    step(); iss_en = 1'b0; rd_req = 1'b1; ra_addr = 3'd2; rb_addr = 3'd5;
    #1;
    check("t3_busy", {24'h0, busy_vec}, 32'h04);
    check("t3_stall", {31'h0, rd_stall}, 32'h1);
    step(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h00AA;
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    check("t3_wb_stall", {31'h0, rd_stall}, 32'h0);
    check("t3_wb_a", {16'h0, a_data}, 32'h00AA);
`else
    check("t3_wb_stall", {31'h0, rd_stall}, 32'h1);
    check("t3_wb_a", {16'h0, a_data}, 32'h0);
`endif
    check("t3_wb_b", {16'h0, b_data}, 32'hBEEF);
    step(); wr_en = 1'b0;
    #1;
    check("t3_after_stall", {31'h0, rd_stall}, 32'h0);
    check("t3_after_a", {16'h0, a_data}, 32'h00AA);
    check("t3_after_busy", {24'h0, busy_vec}, 32'h0);
    rd_req = 1'b0;

    // T4: WAW on R4
    step(); iss_en = 1'b1; iss_addr = 3'd4;
    step();
    #1;
    check("t4_busy", {24'h0, busy_vec}, 32'h10);
    check("t4_iss_stall", {31'h0, iss_stall}, 32'h1);
    step();
    #1 check("t4_busy_held", {24'h0, busy_vec}, 32'h10);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
    #1 check("t4_iss_clr", {31'h0, iss_stall}, 32'h0);
    step(); iss_en = 1'b0; wr_en = 1'b0;
    #1 check("t4_set_wins", {24'h0, busy_vec}, 32'h10);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4445;
    step(); wr_en = 1'b0;
    #1 check("t4_cleared", {24'h0, busy_vec}, 32'h0);

    // T5: dual-port conflict
    iss_en = 1'b1; iss_addr = 3'd1;
    step(); iss_en = 1'b0; ra_addr = 3'd6; rb_addr = 3'd1; rd_req = 1'b1;
    #1;
    check("t5_busy", {24'h0, busy_vec}, 32'h02);
    check("t5_stall_b", {31'h0, rd_stall}, 32'h1);
    rb_addr = 3'd6;
    #1 check("t5_nostall", {31'h0, rd_stall}, 32'h0);
    rb_addr = 3'd1; rd_req = 1'b0;
    #1 check("t5_noreq", {31'h0, rd_stall}, 32'h0);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111;
    step(); wr_en = 1'b0;
    #1 check("t5_clear", {24'h0, busy_vec}, 32'h0);

    // T6: all busy, reset mid-cycle
    for (int i = 0; i < 8; i++) begin
      iss_en = 1'b1; iss_addr = 3'(i);
      step();
    end
    iss_en = 1'b0;
    #1 check("t6_all_busy", {24'h0, busy_vec}, 32'hFF);
    rst = 1'b1;
    #1 check("t6_rst_busy", {24'h0, busy_vec}, 32'h0);
    step(); rst = 1'b0;
    ra_addr = 3'd5; rb_addr = 3'd2; rd_req = 1'b1;
    #1;
    check("t6_a", {16'h0, a_data}, 32'h0);
    check("t6_b", {16'h0, b_data}, 32'h0);
    check("t6_stall", {31'h0, rd_stall}, 32'h0);
    rd_req = 1'b0;

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
